// File: rtl/key_pkg.sv
// Shared constants for the key command path: default key count, code width
// and the key index assignments used by the game/control logic.
// Ports: none (package only).
package key_pkg;

  localparam int NKEYS_DEF  = 5;
  localparam int CODE_W_DEF = 3;

  // Key indices; index 0 has the highest arbitration priority.
  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_RESET = 4;

endpackage

// File: rtl/key_cmd_queue_sync_fifo.sv
// Purpose: DEPTH x W register-array FIFO holding encoded key codes.
// Latency: a write is visible at the head the cycle after wr_en; rd_dat is combinational from the head.
// Backpressure: writes are ignored when full unless a read happens in the same cycle; reads ignored when empty.
// Ports: Clk/Rst (sync, active-high), wr_en/wr_dat, rd_en/rd_dat (0 when empty), full, empty, level.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_dat,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_wr;
  logic          w_rd;

  assign full  = (r_level == LW'(DEPTH));
  assign empty = (r_level == '0);
  assign level = r_level;

  // A write into a full FIFO is legal when the head leaves in the same cycle:
  // the tail slot is then the slot being vacated.
  assign w_rd = rd_en & ~empty;
  assign w_wr = wr_en & (~full | w_rd);

  assign rd_dat = empty ? '0 : r_mem[r_rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_rd)      r_level <= r_level + LW'(1);
      else if (w_rd && !w_wr) r_level <= r_level - LW'(1);
    end
  end

  // Storage needs no reset: the head is masked to 0 while empty.
  always_ff @(posedge Clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/key_cmd_queue.sv
// Purpose: capture debounced key pulses, arbitrate by fixed priority (index 0 first), queue key codes.
// Latency: key_en in cycle N -> pending in N+1 -> cmd_valid/cmd_code in N+2 when the queue is empty.
// Backpressure: cmd_ready stalls the head; a press on a key already pending and not granted is dropped (ovf, drop_cnt).
// Ports: Clk/Rst (sync, active-high), key_en[NKEYS] pulses, cmd_valid/cmd_code/cmd_ready handshake,
//        ovf sticky drop flag with ovf_clr, drop_cnt saturating at 255, level = queue occupancy.
module key_cmd_queue
  import key_pkg::*;
#(
  parameter int NKEYS  = NKEYS_DEF,
  parameter int DEPTH  = 4,
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NKEYS-1:0]         key_en,
  output logic                     cmd_valid,
  output logic [CODE_W-1:0]        cmd_code,
  input  logic                     cmd_ready,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic [7:0]               drop_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  logic [NKEYS-1:0]  r_pend;
  logic              r_ovf;
  logic [7:0]        r_drop_cnt;

  logic [NKEYS-1:0]  w_grant;
  logic [CODE_W-1:0] w_grant_code;
  logic              w_pop;
  logic              w_can_wr;
  logic              w_wr;
  logic              w_drop;
  logic              w_full;
  logic              w_empty;

  assign w_pop    = cmd_valid & cmd_ready;
  // A full queue still takes a write when its head leaves this cycle.
  assign w_can_wr = ~w_full | w_pop;

  // Fixed-priority arbiter: scanning from the top down leaves the lowest set index.
  always_comb begin
    w_grant      = '0;
    w_grant_code = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_grant      = '0;
        w_grant[i]   = 1'b1;
        w_grant_code = CODE_W'(i);
      end
    end
    if (!w_can_wr) begin
      w_grant      = '0;
      w_grant_code = '0;
    end
  end

  assign w_wr = |w_grant;

  // A bit being granted this cycle frees its slot, so a new pulse on it is kept.
  assign w_drop = |(key_en & r_pend & ~w_grant);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_pend     <= '0;
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_pend <= (r_pend & ~w_grant) | key_en;
      // Set has priority over clear so a drop is never hidden.
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign ovf      = r_ovf;
  assign drop_cnt = r_drop_cnt;

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (CODE_W)
  ) u_fifo (
    .Clk    (Clk),
    .Rst    (Rst),
    .wr_en  (w_wr),
    .wr_dat (w_grant_code),
    .rd_en  (w_pop),
    .rd_dat (cmd_code),
    .full   (w_full),
    .empty  (w_empty),
    .level  (level)
  );

  assign cmd_valid = ~w_empty;

endmodule

// File: tb/tb_key_cmd_queue.sv
// Directed bench for key_cmd_queue: latency, priority order, overflow/drop,
// full-queue pass-through, same-cycle re-press, reset override and saturation.
module tb_key_cmd_queue;
  import key_pkg::*;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [4:0] key_en;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ready;
  logic       ovf;
  logic       ovf_clr;
  logic [7:0] drop_cnt;
  logic [2:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  int exp3 [5] = '{3, 1, 2, 0, 4};
  int exp4 [4] = '{2, 3, 4, 0};

  always #5 Clk = ~Clk;

  key_cmd_queue #(.NKEYS(5), .DEPTH(4), .CODE_W(3)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .key_en    (key_en),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_ready (cmd_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .drop_cnt  (drop_cnt),
    .level     (level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  // Drive a one-cycle pulse; returns at the negedge of the following cycle.
  task automatic press(input logic [4:0] k);
    key_en = k;
    tick();
    key_en = '0;
  endtask

  initial begin
    Rst = 1'b1; key_en = '0; cmd_ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    check("rst_valid", cmd_valid, 0);
    check("rst_code",  cmd_code,  0);
    check("rst_level", level,     0);
    check("rst_ovf",   ovf,       0);
    check("rst_drop",  drop_cnt,  0);
    Rst = 1'b0;

    // Single press latency
    press(5'b00100);
    check("t1_n1_valid", cmd_valid, 0);
    tick();
    check("t1_n2_valid", cmd_valid, 1);
    check("t1_n2_code",  cmd_code,  2);
    check("t1_n2_level", level,     1);
    cmd_ready = 1'b1;
    tick();
    check("t1_pop_valid", cmd_valid, 0);
    check("t1_pop_level", level,     0);

    // Simultaneous presses leave lowest index first
    press(5'b10011);
    tick();
    check("t2_code0", cmd_code, 0);
    check("t2_vld0",  cmd_valid, 1);
    tick();
    check("t2_code1", cmd_code, 1);
    tick();
    check("t2_code4", cmd_code, 4);
    tick();
    check("t2_empty", cmd_valid, 0);
    check("t2_ovf",   ovf, 0);
    cmd_ready = 1'b0;

    // Fill, then overflow on a repeated press of a waiting key
    press(5'b1 << KEY_RIGHT);
    press(5'b1 << KEY_DOWN);
    press(5'b1 << KEY_LEFT);
    press(5'b1 << KEY_UP);
    tick();
    check("t3_full_level", level, 4);
    check("t3_full_head",  cmd_code, 3);
    press(5'b1 << KEY_RESET);
    tick();
    check("t3_wait_ovf", ovf, 0);
    press(5'b1 << KEY_RESET);
    check("t3_ovf",   ovf, 1);
    check("t3_drop",  drop_cnt, 1);
    check("t3_level", level, 4);
    cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) check("t3_level_hold", level, 4);
      check($sformatf("t3_drain_vld%0d", i), cmd_valid, 1);
      check($sformatf("t3_drain_code%0d", i), cmd_code, exp3[i]);
      tick();
    end
    check("t3_drained", cmd_valid, 0);
    cmd_ready = 1'b0;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t3_ovf_clr",  ovf, 0);
    check("t3_drop_kept", drop_cnt, 1);

    // Full queue with a waiting key: pop and write in the same cycle
    press(5'b1 << KEY_DOWN);
    press(5'b1 << KEY_LEFT);
    press(5'b1 << KEY_RIGHT);
    press(5'b1 << KEY_RESET);
    press(5'b1 << KEY_UP);
    check("t4_full_level", level, 4);
    check("t4_full_head",  cmd_code, 1);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("t4_pass_level", level, 4);
    check("t4_pass_head",  cmd_code, 2);
    tick();
    check("t4_stall_level", level, 4);
    check("t4_stall_head",  cmd_code, 2);
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_drain_code%0d", i), cmd_code, exp4[i]);
      tick();
    end
    check("t4_drained", cmd_valid, 0);

    // Re-press of a key in the cycle it is granted is kept, not dropped
    key_en = 5'b00100;
    tick();
    tick();
    key_en = '0;
    check("t5_first_vld",  cmd_valid, 1);
    check("t5_first_code", cmd_code, 2);
    tick();
    check("t5_second_vld",  cmd_valid, 1);
    check("t5_second_code", cmd_code, 2);
    tick();
    check("t5_empty", cmd_valid, 0);
    check("t5_drop",  drop_cnt, 1);
    check("t5_ovf",   ovf, 0);

    // Reset overrides pop and key pulses
    cmd_ready = 1'b0;
    key_en = 5'b00011;
    tick();
    tick();
    key_en = '0;
    tick();
    tick();
    check("t6_pre_level", level, 3);
    check("t6_pre_ovf",   ovf, 1);
    check("t6_pre_drop",  drop_cnt, 2);
    Rst = 1'b1; cmd_ready = 1'b1; key_en = 5'b11111;
    tick();
    Rst = 1'b0; cmd_ready = 1'b0; key_en = '0;
    check("t6_rst_level", level, 0);
    check("t6_rst_valid", cmd_valid, 0);
    check("t6_rst_code",  cmd_code, 0);
    check("t6_rst_ovf",   ovf, 0);
    check("t6_rst_drop",  drop_cnt, 0);
    tick();
    check("t6_post_valid", cmd_valid, 0);

    // Drop counter saturation: one drop per cycle from the second cycle on
    cmd_ready = 1'b1;
    key_en = 5'b00011;
    for (int i = 1; i <= 301; i++) begin
      tick();
      if (i == 11)  check("t7_drop10",  drop_cnt, 10);
      if (i == 255) check("t7_drop254", drop_cnt, 254);
      if (i == 256) check("t7_drop255", drop_cnt, 255);
    end
    check("t7_sat", drop_cnt, 255);
    check("t7_ovf", ovf, 1);
    ovf_clr = 1'b1;
    tick();
    check("t7_clr_vs_drop", ovf, 1);
    key_en = '0;
    tick();
    ovf_clr = 1'b0;
    check("t7_clr_only", ovf, 0);
    check("t7_sat_hold", drop_cnt, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
